// File: rtl/gemv_pkg.sv
// Shared types, defaults and helpers for the streaming GEMV engine.
package gemv_pkg;

  localparam int unsigned SZ_DEF     = 3;
  localparam int unsigned DW_DEF     = 16;
  localparam int unsigned N_ROWS_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Accumulator width: full product, growth of an SZ-term sum, one bit of accumulate headroom.
  function automatic int unsigned gemv_aw(input int unsigned sz, input int unsigned dw);
    return 2 * dw + $clog2(sz) + 1;
  endfunction

  // Clamp a signed value into the signed dw-bit range (result still 64 bits wide).
  function automatic logic signed [63:0] sat_to_dw(input logic signed [63:0] v,
                                                   input int unsigned     dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/gemv_dot_pipe.sv
// Two-stage dot-product pipe: S1 holds SZ products, S2 holds sum plus accumulator term.
module gemv_dot_pipe
  import gemv_pkg::*;
#(
  parameter int unsigned SZ = SZ_DEF,
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = gemv_aw(SZ_DEF, DW_DEF),
  parameter int unsigned IW = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_i,
  input  logic             in_valid_i,
  input  logic [SZ*DW-1:0] w_i,
  input  logic [SZ*DW-1:0] row_i,
  input  logic [IW-1:0]    idx_i,
  input  logic [AW-1:0]    acc_add_i,
  output logic             s1_valid_o,
  output logic [IW-1:0]    s1_idx_o,
  output logic [AW-1:0]    s2_next_c,
  output logic             s2_valid_o,
  output logic [IW-1:0]    s2_idx_o,
  output logic [AW-1:0]    s2_sum_o
);

  localparam int unsigned PW = 2 * DW;

  logic signed [PW-1:0] prod_c [SZ];
  logic signed [PW-1:0] prod_d [SZ];
  logic signed [PW-1:0] prod_q [SZ];
  logic signed [AW-1:0] sum_c;

  logic          s1_valid_d, s1_valid_q;
  logic [IW-1:0] s1_idx_d,   s1_idx_q;
  logic          s2_valid_d, s2_valid_q;
  logic [IW-1:0] s2_idx_d,   s2_idx_q;
  logic [AW-1:0] s2_sum_d,   s2_sum_q;

  // Element-wise signed products of weight and row.
  always_comb begin
    for (int i = 0; i < int'(SZ); i++) begin
      prod_c[i] = PW'($signed(w_i[i*DW +: DW])) * PW'($signed(row_i[i*DW +: DW]));
    end
  end

  // Reduce registered products and add the accumulator term.
  always_comb begin
    sum_c = $signed(acc_add_i);
    for (int i = 0; i < int'(SZ); i++) begin
      sum_c = sum_c + AW'(prod_q[i]);
    end
  end

  // Stage loads; everything holds while adv_i is low.
  always_comb begin
    prod_d     = prod_q;
    s1_valid_d = s1_valid_q;
    s1_idx_d   = s1_idx_q;
    s2_valid_d = s2_valid_q;
    s2_idx_d   = s2_idx_q;
    s2_sum_d   = s2_sum_q;
    if (adv_i) begin
      s1_valid_d = in_valid_i;
      if (in_valid_i) begin
        prod_d   = prod_c;
        s1_idx_d = idx_i;
      end
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_idx_d = s1_idx_q;
        s2_sum_d = AW'(sum_c);
      end
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SZ); i++) begin
        prod_q[i] <= '0;
      end
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_idx_q   <= '0;
      s2_sum_q   <= '0;
    end else begin
      prod_q     <= prod_d;
      s1_valid_q <= s1_valid_d;
      s1_idx_q   <= s1_idx_d;
      s2_valid_q <= s2_valid_d;
      s2_idx_q   <= s2_idx_d;
      s2_sum_q   <= s2_sum_d;
    end
  end

  assign s1_valid_o = s1_valid_q;
  assign s1_idx_o   = s1_idx_q;
  assign s2_next_c  = AW'(sum_c);
  assign s2_valid_o = s2_valid_q;
  assign s2_idx_o   = s2_idx_q;
  assign s2_sum_o   = s2_sum_q;

endmodule

// File: rtl/gemv_stream_engine.sv
// Weight-stationary GEMV: w latched per job, A streamed a row per cycle, y saturated out.
module gemv_stream_engine
  import gemv_pkg::*;
#(
  parameter int unsigned SZ     = SZ_DEF,
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned N_ROWS = N_ROWS_DEF,
  parameter int unsigned AW     = gemv_aw(SZ, DW),
  localparam int unsigned IW    = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             accum_i,
  input  logic [SZ*DW-1:0] w_i,
  input  logic             a_valid_i,
  output logic             a_ready_o,
  input  logic [SZ*DW-1:0] a_row_i,
  output logic             o_valid_o,
  input  logic             o_ready_i,
  output logic [DW-1:0]    o_data_o,
  output logic [IW-1:0]    o_idx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovf_o
);

  localparam int unsigned CW = $clog2(N_ROWS) + 1;

  state_t state_d, state_q;

  logic [SZ*DW-1:0] w_d,         w_q;
  logic             accum_d,     accum_q;
  logic [CW-1:0]    in_cnt_d,    in_cnt_q;
  logic [CW-1:0]    out_cnt_d,   out_cnt_q;
  logic             ovf_d,       ovf_q;
  logic             out_valid_d, out_valid_q;
  logic [DW-1:0]    out_data_d,  out_data_q;
  logic [IW-1:0]    out_idx_d,   out_idx_q;
  logic [AW-1:0]    acc_mem_d [N_ROWS];
  logic [AW-1:0]    acc_mem_q [N_ROWS];

  logic             adv_c;
  logic             accept_c;
  logic             out_hs_c;
  logic             start_ok_c;
  logic             last_in_c;
  logic             last_out_c;
  logic [AW-1:0]    acc_add_c;
  logic signed [63:0] s2_wide_c;
  logic signed [63:0] sat_c;
  logic             clamp_c;

  logic             s1_valid;
  logic [IW-1:0]    s1_idx;
  logic [AW-1:0]    s2_next;
  logic             s2_valid;
  logic [IW-1:0]    s2_idx;
  logic [AW-1:0]    s2_sum;

  // Handshake and job-boundary qualifiers.
  assign adv_c      = !out_valid_q || o_ready_i;
  assign accept_c   = a_valid_i && a_ready_o;
  assign out_hs_c   = out_valid_q && o_ready_i;
  assign start_ok_c = (state_q == IDLE) && start_i;
  assign last_in_c  = accept_c && (in_cnt_q == CW'(N_ROWS - 1));
  assign last_out_c = out_hs_c && (out_cnt_q == CW'(N_ROWS - 1));

  // Accumulate term for the row currently leaving S1.
  assign acc_add_c = accum_q ? acc_mem_q[s1_idx] : '0;

  // Saturation of the S2 value into the output width.
  assign s2_wide_c = 64'($signed(s2_sum));
  assign sat_c     = sat_to_dw(s2_wide_c, DW);
  assign clamp_c   = (sat_c != s2_wide_c);

  gemv_dot_pipe #(
    .SZ (SZ),
    .DW (DW),
    .AW (AW),
    .IW (IW)
  ) u_dot_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .adv_i      (adv_c),
    .in_valid_i (accept_c),
    .w_i        (w_q),
    .row_i      (a_row_i),
    .idx_i      (IW'(in_cnt_q)),
    .acc_add_i  (acc_add_c),
    .s1_valid_o (s1_valid),
    .s1_idx_o   (s1_idx),
    .s2_next_c  (s2_next),
    .s2_valid_o (s2_valid),
    .s2_idx_o   (s2_idx),
    .s2_sum_o   (s2_sum)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i)    state_d = RUN;
      RUN:     if (last_in_c)  state_d = DRAIN;
      DRAIN:   if (last_out_c) state_d = DONE;
      DONE:                    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // FSM-decoded outputs.
  always_comb begin
    busy_o    = 1'b0;
    done_o    = 1'b0;
    a_ready_o = 1'b0;
    case (state_q)
      RUN: begin
        busy_o    = 1'b1;
        a_ready_o = adv_c;
      end
      DRAIN:   busy_o = 1'b1;
      DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Job registers, counters, accumulator memory and output stage.
  always_comb begin
    w_d         = w_q;
    accum_d     = accum_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    acc_mem_d   = acc_mem_q;

    if (accept_c) begin
      in_cnt_d = in_cnt_q + CW'(1);
    end
    if (out_hs_c) begin
      out_cnt_d = out_cnt_q + CW'(1);
    end

    if (adv_c) begin
      out_valid_d = s2_valid;
      if (s2_valid) begin
        out_data_d = DW'(sat_c);
        out_idx_d  = s2_idx;
        if (clamp_c) begin
          ovf_d = 1'b1;
        end
      end
      // acc_mem keeps the unsaturated value for later accumulate jobs.
      if (s1_valid) begin
        acc_mem_d[s1_idx] = s2_next;
      end
    end

    if (start_ok_c) begin
      w_d       = w_i;
      accum_d   = accum_i;
      in_cnt_d  = '0;
      out_cnt_d = '0;
      ovf_d     = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q         <= '0;
      accum_q     <= 1'b0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      for (int r = 0; r < int'(N_ROWS); r++) begin
        acc_mem_q[r] <= '0;
      end
    end else begin
      w_q         <= w_d;
      accum_q     <= accum_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      acc_mem_q   <= acc_mem_d;
    end
  end

  assign o_valid_o = out_valid_q;
  assign o_data_o  = out_data_q;
  assign o_idx_o   = out_idx_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_gemv_stream_engine.sv
// Directed bench for gemv_stream_engine with a queue-based result model.
module tb_gemv_stream_engine;

  localparam int SZ = 3;
  localparam int DW = 16;
  localparam int NR = 3;
  localparam int IW = 2;
  localparam int BUDGET = 300;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_i = 1'b0;
  logic             accum_i = 1'b0;
  logic [SZ*DW-1:0] w_i = '0;
  logic             a_valid_i = 1'b0;
  logic             a_ready_o;
  logic [SZ*DW-1:0] a_row_i = '0;
  logic             o_valid_o;
  logic             o_ready_i = 1'b1;
  logic [DW-1:0]    o_data_o;
  logic [IW-1:0]    o_idx_o;
  logic             busy_o;
  logic             done_o;
  logic             ovf_o;

  gemv_stream_engine #(
    .SZ     (SZ),
    .DW     (DW),
    .N_ROWS (NR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .accum_i   (accum_i),
    .w_i       (w_i),
    .a_valid_i (a_valid_i),
    .a_ready_o (a_ready_o),
    .a_row_i   (a_row_i),
    .o_valid_o (o_valid_o),
    .o_ready_i (o_ready_i),
    .o_data_o  (o_data_o),
    .o_idx_o   (o_idx_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .ovf_o     (ovf_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: job operands, per-row accumulators, pending results.
  int     jw[SZ];
  int     jr[NR][SZ];
  longint acc_model[NR];
  int     exp_d_q[$];
  int     exp_i_q[$];
  bit     job_ovf_exp;
  int     got[NR];
  int     done_cnt = 0;
  bit     lat_arm = 1'b0;
  int     acc_edge = -1;
  int     first_valid_cyc = -1;

  function automatic logic [SZ*DW-1:0] pack3(input int a, input int b, input int c);
    return {16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic set_w(input int a, input int b, input int c);
    jw[0] = a; jw[1] = b; jw[2] = c;
  endtask

  task automatic set_row(input int r, input int a, input int b, input int c);
    jr[r][0] = a; jr[r][1] = b; jr[r][2] = c;
  endtask

  // y[r] = w . A[r] (+ previous y[r] when accumulating), then clamp to 16-bit signed.
  function automatic void model_accept(input int r, input bit accum);
    longint v;
    int     c;
    v = 0;
    for (int i = 0; i < SZ; i++) v += longint'(jw[i]) * longint'(jr[r][i]);
    if (accum) v += acc_model[r];
    acc_model[r] = v;
    if (v > 32767) begin
      c = 32767; job_ovf_exp = 1'b1;
    end else if (v < -32768) begin
      c = -32768; job_ovf_exp = 1'b1;
    end else begin
      c = int'(v);
    end
    exp_d_q.push_back(c);
    exp_i_q.push_back(r);
  endfunction

  // Output checker: runs every cycle, compares handshaked results and hold/backpressure rules.
  bit            prev_hold = 1'b0;
  logic [DW-1:0] prev_data;
  logic [IW-1:0] prev_idx;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", o_valid_o, 1);
        chk("hold_data", o_data_o, prev_data);
        chk("hold_idx", o_idx_o, prev_idx);
      end
      if (o_valid_o && !o_ready_i) chk("a_ready_stall", a_ready_o, 0);
      if (lat_arm && o_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (o_valid_o && o_ready_i) begin
        if (exp_d_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          int ed, ei;
          ed = exp_d_q.pop_front();
          ei = exp_i_q.pop_front();
          chk("out_data", longint'($signed(o_data_o)), ed);
          chk("out_idx", o_idx_o, ei);
          got[o_idx_o] = int'($signed(o_data_o));
        end
      end
      prev_hold = o_valid_o && !o_ready_i;
      prev_data = o_data_o;
      prev_idx  = o_idx_o;
      if (done_o) done_cnt++;
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_o_valid"}, o_valid_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_ovf"}, ovf_o, 0);
    chk({tag, "_a_ready"}, a_ready_o, 0);
    chk({tag, "_o_data"}, o_data_o, 0);
    chk({tag, "_o_idx"}, o_idx_o, 0);
  endtask

  // One job: start, stream NR rows, optional stall / start poke / abort, wait for done.
  task automatic run_job(input bit accum, input int stall_at, input int stall_len,
                         input bit poke, input int abort_after);
    int sent, stall_left, budget, done_before;
    bit stalled, poked;
    for (int r = 0; r < NR; r++) got[r] = -99999;
    job_ovf_exp = 1'b0;
    done_before = done_cnt;
    sent = 0; stall_left = 0; stalled = 1'b0; poked = 1'b0;
    @(negedge clk);
    w_i = pack3(jw[0], jw[1], jw[2]);
    accum_i = accum; start_i = 1'b1; a_valid_i = 1'b0; o_ready_i = 1'b1;
    for (budget = 0; budget < BUDGET; budget++) begin
      @(negedge clk);
      if (done_cnt != done_before) break;
      if (abort_after >= 0 && sent >= abort_after) begin
        rst_n = 1'b0; a_valid_i = 1'b0; start_i = 1'b0; o_ready_i = 1'b1;
        exp_d_q.delete(); exp_i_q.delete();
        for (int r = 0; r < NR; r++) acc_model[r] = 0;
        #1;
        check_idle_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      start_i = 1'b0;
      if (poke && !poked && sent == 1) begin
        start_i = 1'b1; w_i = pack3(9, 9, 9); accum_i = !accum; poked = 1'b1;
      end
      if (stall_at >= 0 && !stalled && sent == stall_at) begin
        stall_left = stall_len; stalled = 1'b1;
      end
      o_ready_i = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (sent < NR) begin
        a_valid_i = 1'b1;
        a_row_i = pack3(jr[sent][0], jr[sent][1], jr[sent][2]);
      end else begin
        a_valid_i = 1'b0;
      end
      #1;
      if (a_valid_i && a_ready_o) begin
        if (lat_arm && sent == 0) acc_edge = cyc + 1;
        model_accept(sent, accum);
        sent++;
      end
    end
    a_valid_i = 1'b0; o_ready_i = 1'b1; start_i = 1'b0;
    chk("job_timeout", (budget < BUDGET) ? 1 : 0, 1);
    repeat (3) @(negedge clk);
    #3;
    chk("done_once", done_cnt - done_before, 1);
    chk("ovf_sticky", ovf_o, job_ovf_exp);
    chk("busy_idle", busy_o, 0);
    chk("queue_empty", exp_d_q.size(), 0);
  endtask

  task automatic chk_got(input string tag, input int y0, input int y1, input int y2);
    chk({tag, "_y0"}, got[0], y0);
    chk({tag, "_y1"}, got[1], y1);
    chk({tag, "_y2"}, got[2], y2);
  endtask

  initial begin
    for (int r = 0; r < NR; r++) acc_model[r] = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: fresh job, latency and literal results
    set_w(1, 2, 3);
    set_row(0, 1, 2, 3); set_row(1, 4, 5, 6); set_row(2, 7, 8, 9);
    lat_arm = 1'b1;
    run_job(1'b0, -1, 0, 1'b0, -1);
    lat_arm = 1'b0;
    chk_got("fresh", 14, 32, 50);
    chk("latency", first_valid_cyc - acc_edge, 2);
    chk("fresh_ovf", ovf_o, 0);

    // 2: accumulate on top of job 1, then fresh again
    set_w(2, 4, 6);
    run_job(1'b1, -1, 0, 1'b0, -1);
    chk_got("accum", 42, 96, 150);
    run_job(1'b0, -1, 0, 1'b0, -1);
    chk_got("refresh", 28, 64, 100);

    // 3: positive and negative saturation
    set_w(32767, 32767, 32767);
    for (int r = 0; r < NR; r++) set_row(r, 32767, 32767, 32767);
    run_job(1'b0, -1, 0, 1'b0, -1);
    chk_got("sat_pos", 32767, 32767, 32767);
    chk("sat_pos_ovf", ovf_o, 1);
    set_w(-32768, -32768, -32768);
    run_job(1'b0, -1, 0, 1'b0, -1);
    chk_got("sat_neg", -32768, -32768, -32768);
    chk("sat_neg_ovf", ovf_o, 1);

    // 4: output backpressure for 5 cycles mid-job, mixed signs
    set_w(3, -2, 1);
    set_row(0, 1, 1, 1); set_row(1, 2, -1, 0); set_row(2, -4, 5, 6);
    run_job(1'b0, 1, 5, 1'b0, -1);
    chk_got("stall", 2, 8, -16);
    chk("stall_ovf_clr", ovf_o, 0);

    // 5: rows offered in IDLE are refused; start during RUN is ignored
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a_valid_i = 1'b1;
      a_row_i = pack3(5, 5, 5);
      #1;
      chk("idle_a_ready", a_ready_o, 0);
    end
    @(negedge clk);
    a_valid_i = 1'b0;
    #1;
    chk("idle_no_out", o_valid_o, 0);
    set_w(1, 2, 3);
    set_row(0, 1, 2, 3); set_row(1, 4, 5, 6); set_row(2, 7, 8, 9);
    run_job(1'b0, -1, 0, 1'b1, -1);
    chk_got("poke", 14, 32, 50);

    // 6: reset after two rows, then an accumulate job must equal a fresh one
    run_job(1'b0, -1, 0, 1'b0, 2);
    repeat (2) @(negedge clk);
    run_job(1'b1, -1, 0, 1'b0, -1);
    chk_got("post_reset", 14, 32, 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
